wishbone_slave_mem: RTL and testbench
=====================================

WISHBONE_SLAVE_MEM -- requirements
Module: wishbone_slave_mem

Interface
REQ-001 Parameter BASE, default 32'h0000_0000, meaning the slave's base address; only bits [31:6] are compared.
REQ-002 Parameter WAIT_CYCLES, default 1, meaning the number of wait cycles inserted before each response; legal range is 0-15.
REQ-003 Port clk, input, width 1, meaning the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, width 1, meaning reset; reset is synchronous and active-high.
REQ-005 Port adr, input, width 32, meaning the Wishbone byte address from the master.
REQ-006 Port din, input, width 32, meaning the write data from the master (the master's dout).
REQ-007 Port dout, output, width 32, meaning the read data to the master (the master's din).
REQ-008 Port cyc, input, width 1, meaning bus cycle in progress.
REQ-009 Port stb, input, width 1, meaning strobe / valid transfer.
REQ-010 Port sel, input, width 4, meaning byte-lane selects; sel[i] selects din/dout bits [8i+7:8i].
REQ-011 Port we, input, width 1, meaning 1 = write and 0 = read.
REQ-012 Port ack, output, width 1, meaning normal termination.
REQ-013 Port err, output, width 1, meaning error termination.
REQ-014 Port rty, output, width 1, meaning retry termination.

Function
REQ-015 Storage shall be 16 x 32-bit registers, indexed by adr[5:2]; adr[1:0] is ignored.
REQ-016 The FSM shall have three states: IDLE, WAIT, RESP.
REQ-017 In IDLE, when cyc & stb is sampled high, the slave shall latch adr, din, sel and we, then go to WAIT if WAIT_CYCLES > 0, else to RESP.
REQ-018 WAIT shall last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, and then go to RESP.
REQ-019 RESP shall last exactly one cycle; exactly one of ack, err or rty is high in it, then the FSM returns to IDLE.
REQ-020 Latency: if cyc & stb is sampled at edge k, the response shall be visible after edge k+1+WAIT_CYCLES.
REQ-021 ack, err and rty shall be low in every state other than RESP; the three shall be mutually exclusive.
REQ-022 err shall be asserted when latched adr[31:6] != BASE[31:6], or when latched sel == 4'b0000.
REQ-023 Register 15 bit 0 is LOCK; it is writable and readable like any other register.
REQ-024 rty shall be asserted for a write to index 0-14 while LOCK = 1 and err does not apply; memory shall not be changed.
REQ-025 In all other cases ack shall be asserted.
REQ-026 A write shall commit at the RESP edge, only when ack is asserted; only lanes with sel[i] = 1 are updated.
REQ-027 A write to index 15 with sel[0] = 1 shall update LOCK, including clearing it while locked; writes to index 15 are never retried.
REQ-028 For a read with ack, dout shall equal the full 32-bit stored word during RESP, regardless of sel; dout shall be 0 at all other times, including err and rty cycles.
REQ-029 Read data shall reflect all writes that have committed before the read's RESP cycle.
REQ-030 Abort: if cyc is sampled low while in WAIT, the FSM shall return to IDLE with no response and no write.
REQ-031 Back-to-back: the IDLE cycle after RESP is mandatory; a strobe still held in that cycle starts a new transaction.
REQ-032 Inputs shall be ignored while in WAIT or RESP, except for the cyc abort check in WAIT.

Reset
REQ-033 While rst = 1 at a rising edge, the FSM shall go to IDLE, the wait counter to 0, and all 16 registers (including LOCK) to 0.
REQ-034 While rst = 1, ack, err, rty and dout shall all be 0.
REQ-035 A reset in WAIT or RESP shall abandon the transaction: no response and no write.

Verification
REQ-036 With WAIT_CYCLES = 1, BASE = 0: write adr 0x08, data 0xDEADBEEF, sel 0xF; then read adr 0x08 -> ack 2 cycles after strobe sample; dout = 0xDEADBEEF.
REQ-037 Partial write: write 0x11223344 to adr 0x0C with sel 0xF, then 0xAABBCCDD with sel 0b0101 -> read returns 0x11BB33DD.
REQ-038 Read adr 0x40 (bits [31:6] mismatch), and separately any access with sel 0 -> err for one cycle, dout = 0, memory unchanged.
REQ-039 Lock: write 0x1 to adr 0x3C; write adr 0x00 -> rty and memory unchanged; read adr 0x00 -> ack; write 0x0 to adr 0x3C -> ack; write adr 0x00 -> ack and committed.
REQ-040 With WAIT_CYCLES = 3: drop cyc in the 2nd wait cycle of a write -> no ack/err/rty, no write; then assert rst during WAIT of a new access -> outputs 0, memory cleared, next access after reset acks normally.

Source files
------------

// File: rtl/wishbone_slave_mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wishbone_slave_mem_if                                           |
// | Purpose  : Wishbone classic bus bundle between one master and the          |
// |            wishbone_slave_mem register file. Directions are named from     |
// |            the slave's point of view: din is the master's write data,      |
// |            dout is the slave's read data.                                  |
// | Signals  : adr[31:0]  byte address            (master -> slave)            |
// |            din[31:0]  write data              (master -> slave)            |
// |            dout[31:0] read data               (slave  -> master)           |
// |            cyc, stb   cycle / strobe          (master -> slave)            |
// |            sel[3:0]   byte-lane selects       (master -> slave)            |
// |            we         1 = write, 0 = read     (master -> slave)            |
// |            ack/err/rty termination            (slave  -> master)           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface wishbone_slave_mem_if;
  logic [31:0] adr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        cyc;
  logic        stb;
  logic [3:0]  sel;
  logic        we;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output adr, din, cyc, stb, sel, we,
    input  dout, ack, err, rty
  );

  modport slave (
    input  adr, din, cyc, stb, sel, we,
    output dout, ack, err, rty
  );
endinterface
`default_nettype wire

// File: rtl/wishbone_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wishbone_slave_mem                                              |
// | Purpose  : Wishbone classic slave holding 16 x 32-bit registers decoded    |
// |            from adr[5:2] inside a 64-byte window at BASE. Each accepted    |
// |            strobe walks IDLE -> WAIT (WAIT_CYCLES cycles) -> RESP -> IDLE. |
// |            Register 15 bit 0 is LOCK: while set, writes to registers 0-14  |
// |            are answered with rty and leave memory untouched.               |
// | Ports    : clk  - clock, all state on rising edge                          |
// |            rst  - synchronous active-high reset                            |
// |            bus  - wishbone_slave_mem_if.slave (adr, din, dout, cyc, stb,   |
// |                   sel, we, ack, err, rty)                                  |
// | Params   : BASE        - window base, only bits [31:6] are compared        |
// |            WAIT_CYCLES - wait cycles before each response, 0..15           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wishbone_slave_mem #(
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input wire                  clk,
  input wire                  rst,
  wishbone_slave_mem_if.slave bus
);

  // Wait-state reload value; the counter is 4 bits wide so 15 is the ceiling.
  localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t       state_q, state_d;
  logic [3:0]   cnt_q,   cnt_d;
  logic [31:2]  adr_q,   adr_d;
  logic [31:0]  din_q,   din_d;
  logic [3:0]   sel_q,   sel_d;
  logic         we_q,    we_d;
  logic         ack_q,   ack_d;
  logic         err_q,   err_d;
  logic         rty_q,   rty_d;
  logic [31:0]  dout_q,  dout_d;
  logic [31:0]  mem_q [16];
  logic [31:0]  mem_d [16];

  // Byte offset within a word carries no meaning for this slave.
  logic [1:0]   adr_lsb_unused;
  assign adr_lsb_unused = bus.adr[1:0];

  // ---------------------------------------------------------------------------
  // Request view used to classify the response.
  // With zero wait states the response is decided in the same cycle the
  // strobe is accepted, so the classifier looks straight at the bus while in
  // IDLE and at the latched copy otherwise. Memory cannot change between the
  // accept and the response because only one transaction is ever in flight.
  // ---------------------------------------------------------------------------
  logic [31:2]  req_adr;
  logic [3:0]   req_sel;
  logic         req_we;
  logic [3:0]   req_idx;
  logic         lock;
  logic         req_err;
  logic         req_rty;
  logic         req_ack;

  always_comb begin
    if (state_q == ST_IDLE) begin
      req_adr = bus.adr[31:2];
      req_sel = bus.sel;
      req_we  = bus.we;
    end else begin
      req_adr = adr_q;
      req_sel = sel_q;
      req_we  = we_q;
    end
    req_idx = req_adr[5:2];
    lock    = mem_q[15][0];
    // Decode errors take priority; register 15 is exempt from the lock so
    // software can always release it.
    req_err = (req_adr[31:6] != BASE[31:6]) || (req_sel == 4'b0000);
    req_rty = !req_err && req_we && (req_idx != 4'd15) && lock;
    req_ack = !req_err && !req_rty;
  end

  // ---------------------------------------------------------------------------
  // Byte-lane write mask for the committed write.
  // ---------------------------------------------------------------------------
  logic [31:0]  wmask;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign wmask[8*i +: 8] = {8{sel_q[i]}};
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic        load_resp;
  logic [3:0]  commit_idx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    din_d      = din_q;
    sel_d      = sel_q;
    we_d       = we_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rty_d      = 1'b0;
    dout_d     = 32'h0000_0000;
    mem_d      = mem_q;
    load_resp  = 1'b0;
    commit_idx = adr_q[5:2];

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cyc && bus.stb) begin
          adr_d = bus.adr[31:2];
          din_d = bus.din;
          sel_d = bus.sel;
          we_d  = bus.we;
          if (C_WAIT_LOAD != 4'd0) begin
            state_d = ST_WAIT;
            cnt_d   = C_WAIT_LOAD;
          end else begin
            state_d   = ST_RESP;
            load_resp = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        // Only cyc is observed here; a master dropping it abandons the access.
        if (!bus.cyc) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d   = ST_RESP;
          cnt_d     = 4'd0;
          load_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        // The write lands on the edge that closes RESP, so a reset asserted
        // during RESP still discards it.
        state_d = ST_IDLE;
        if (ack_q && we_q) begin
          mem_d[commit_idx] = (mem_q[commit_idx] & ~wmask) | (din_q & wmask);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Termination flags and read data are registered on entry to RESP so they
    // are clean for exactly that one cycle.
    if (load_resp) begin
      ack_d  = req_ack;
      err_d  = req_err;
      rty_d  = req_rty;
      dout_d = (req_ack && !req_we) ? mem_q[req_idx] : 32'h0000_0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      din_q   <= 32'h0000_0000;
      sel_q   <= 4'b0000;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      dout_q  <= 32'h0000_0000;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      din_q   <= din_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      dout_q  <= dout_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.ack  = ack_q;
  assign bus.err  = err_q;
  assign bus.rty  = rty_q;
  assign bus.dout = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wishbone_slave_mem                                           |
// | Purpose  : Self-checking bench for wishbone_slave_mem. Three instances     |
// |            (WAIT_CYCLES 1, 3 and 0, one with a non-zero BASE) are driven   |
// |            by directed and random transactions and compared with a         |
// |            word-array model that applies the access rules directly.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_wishbone_slave_mem;

  localparam int          NDUT  = 3;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0000;
  localparam logic [31:0] BASE2 = 32'hABCD_0040;
  localparam int          W0    = 1;
  localparam int          W1    = 3;
  localparam int          W2    = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] m_adr [NDUT];
  logic [31:0] m_din [NDUT];
  logic        m_cyc [NDUT];
  logic        m_stb [NDUT];
  logic [3:0]  m_sel [NDUT];
  logic        m_we  [NDUT];
  logic [31:0] s_dout[NDUT];
  logic        s_ack [NDUT];
  logic        s_err [NDUT];
  logic        s_rty [NDUT];

  logic [31:0] model_mem [NDUT][16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wishbone_slave_mem_if bus0();
  wishbone_slave_mem_if bus1();
  wishbone_slave_mem_if bus2();

`define WB_HOOK(BUS, N) \
  assign BUS.adr  = m_adr[N]; \
  assign BUS.din  = m_din[N]; \
  assign BUS.cyc  = m_cyc[N]; \
  assign BUS.stb  = m_stb[N]; \
  assign BUS.sel  = m_sel[N]; \
  assign BUS.we   = m_we[N];  \
  assign s_dout[N] = BUS.dout; \
  assign s_ack[N]  = BUS.ack;  \
  assign s_err[N]  = BUS.err;  \
  assign s_rty[N]  = BUS.rty;

  `WB_HOOK(bus0, 0)
  `WB_HOOK(bus1, 1)
  `WB_HOOK(bus2, 2)
`undef WB_HOOK

  wishbone_slave_mem #(.BASE(BASE0), .WAIT_CYCLES(W0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  wishbone_slave_mem #(.BASE(BASE1), .WAIT_CYCLES(W1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  wishbone_slave_mem #(.BASE(BASE2), .WAIT_CYCLES(W2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic int wait_of(input int d);
    case (d)
      0:       return W0;
      1:       return W1;
      default: return W2;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int d);
    case (d)
      0:       return BASE0;
      1:       return BASE1;
      default: return BASE2;
    endcase
  endfunction

  // 0 none, 1 ack, 2 err, 3 rty, 4 several at once, 5 unknown
  function automatic int obs_code(input int d);
    int n;
    if ($isunknown({s_ack[d], s_err[d], s_rty[d]})) return 5;
    n = int'(s_ack[d]) + int'(s_err[d]) + int'(s_rty[d]);
    if (n > 1) return 4;
    if (s_ack[d]) return 1;
    if (s_err[d]) return 2;
    if (s_rty[d]) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] word_adr(input int d, input int idx);
    logic [31:0] b;
    b = base_of(d);
    return {b[31:6], 4'(idx), 2'b00};
  endfunction

  task automatic clear_model();
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 16; i++)
        model_mem[d][i] = 32'h0;
  endtask

  // One transaction on instance d, started at a negedge with the slave idle
  // (extra = 0) or still in RESP of a held previous access (extra = 1).
  task automatic access(input int d, input logic we, input logic [31:0] adr,
                        input logic [31:0] data, input logic [3:0] sel,
                        input bit hold, input int extra,
                        output logic [31:0] rdata, output int code);
    logic [31:0] b;
    logic [31:0] mask;
    logic [31:0] exp_dout;
    int          exp_code;
    int          idx;
    int          lat;
    int          got;
    b   = base_of(d);
    idx = int'(adr[5:2]);
    if ((adr[31:6] != b[31:6]) || (sel == 4'b0000))            exp_code = 2;
    else if (we && (idx != 15) && (model_mem[d][15][0] == 1'b1)) exp_code = 3;
    else                                                         exp_code = 1;
    exp_dout = (exp_code == 1 && !we) ? model_mem[d][idx] : 32'h0;

    m_adr[d] = adr; m_din[d] = data; m_sel[d] = sel; m_we[d] = we;
    m_cyc[d] = 1'b1; m_stb[d] = 1'b1;

    lat = 0;
    got = 0;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      got = obs_code(d);
      if (got != 0) begin
        lat = j;
        break;
      end
      // Once the strobe is accepted the slave must ignore these.
      if (j > extra) begin
        m_adr[d] = $urandom; m_din[d] = $urandom;
        m_sel[d] = 4'($urandom_range(15)); m_we[d] = 1'($urandom_range(1));
      end
    end
    rdata = s_dout[d];
    code  = got;

    checks++;
    if (lat != wait_of(d) + 1 + extra) begin
      errors++;
      $display("FAIL latency d=%0d adr=%h got=%0d exp=%0d", d, adr, lat, wait_of(d) + 1 + extra);
    end
    checks++;
    if (got != exp_code) begin
      errors++;
      $display("FAIL resp_kind d=%0d adr=%h we=%0b sel=%h got=%0d exp=%0d", d, adr, we, sel, got, exp_code);
    end
    checks++;
    if (rdata !== exp_dout) begin
      errors++;
      $display("FAIL dout d=%0d adr=%h got=%h exp=%h", d, adr, rdata, exp_dout);
    end

    if (exp_code == 1 && we) begin
      mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      model_mem[d][idx] = (model_mem[d][idx] & ~mask) | (data & mask);
    end

    if (!hold) begin
      m_cyc[d] = 1'b0; m_stb[d] = 1'b0;
      @(negedge clk);
      checks++;
      if (obs_code(d) != 0 || s_dout[d] !== 32'h0) begin
        errors++;
        $display("FAIL one_cycle d=%0d code=%0d dout=%h exp code=0 dout=0", d, obs_code(d), s_dout[d]);
      end
    end
  endtask

  task automatic check_quiet(input string name);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (obs_code(d) != 0 || s_dout[d] !== 32'h0) begin
        errors++;
        $display("FAIL %s d=%0d code=%0d dout=%h exp code=0 dout=0", name, d, obs_code(d), s_dout[d]);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int          code;
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      m_adr[d] = 32'h0; m_din[d] = 32'h0; m_sel[d] = 4'hF; m_we[d] = 1'b1;
      m_cyc[d] = 1'b1;  m_stb[d] = 1'b1;
    end
    clear_model();
    repeat (3) begin
      @(negedge clk);
      check_quiet("reset_outputs");
    end
    for (int d = 0; d < NDUT; d++) begin
      m_cyc[d] = 1'b0; m_stb[d] = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    check_quiet("post_reset_idle");
    for (int d = 0; d < NDUT; d++)
      access(d, 1'b0, word_adr(d, 3 * d + 1), 32'h0, 4'hF, 1'b0, 0, rd, code);
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    int          code;
    access(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 1'b0, 0, rd, code);
    access(0, 1'b0, 32'h08, 32'h0, 4'hF, 1'b0, 0, rd, code);
    checks++;
    if (rd !== 32'hDEADBEEF || code != 1) begin
      errors++;
      $display("FAIL basic_read got=%h/%0d exp=deadbeef/1", rd, code);
    end
  endtask

  task automatic test_partial_write();
    logic [31:0] rd;
    int          code;
    access(0, 1'b1, 32'h0C, 32'h11223344, 4'hF, 1'b0, 0, rd, code);
    access(0, 1'b1, 32'h0C, 32'hAABBCCDD, 4'b0101, 1'b0, 0, rd, code);
    access(0, 1'b0, 32'h0C, 32'h0, 4'b0001, 1'b0, 0, rd, code);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL partial_write got=%h exp=11bb33dd", rd);
    end
  endtask

  task automatic test_error();
    logic [31:0] rd;
    int          code;
    access(0, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 0, rd, code);
    checks++;
    if (code != 2 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_range got=%0d/%h exp=2/0", code, rd);
    end
    access(0, 1'b1, 32'h08, 32'h12345678, 4'h0, 1'b0, 0, rd, code);
    checks++;
    if (code != 2) begin
      errors++;
      $display("FAIL err_sel0 got=%0d exp=2", code);
    end
    access(0, 1'b1, 32'h48, 32'h0BADF00D, 4'hF, 1'b0, 0, rd, code);
    access(0, 1'b0, 32'h08, 32'h0, 4'hF, 1'b0, 0, rd, code);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL err_no_write got=%h exp=deadbeef", rd);
    end
    // Same word offset on the non-zero-base instance lies outside its window.
    access(2, 1'b0, 32'h08, 32'h0, 4'hF, 1'b0, 0, rd, code);
  endtask

  task automatic test_lock();
    logic [31:0] rd;
    int          code;
    access(0, 1'b1, 32'h3C, 32'h1, 4'hF, 1'b0, 0, rd, code);
    access(0, 1'b1, 32'h00, 32'h55AA55AA, 4'hF, 1'b0, 0, rd, code);
    checks++;
    if (code != 3) begin
      errors++;
      $display("FAIL lock_rty got=%0d exp=3", code);
    end
    access(0, 1'b0, 32'h00, 32'h0, 4'hF, 1'b0, 0, rd, code);
    checks++;
    if (code != 1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL lock_read got=%0d/%h exp=1/0", code, rd);
    end
    access(0, 1'b1, 32'h3C, 32'h0, 4'hF, 1'b0, 0, rd, code);
    checks++;
    if (code != 1) begin
      errors++;
      $display("FAIL unlock got=%0d exp=1", code);
    end
    access(0, 1'b1, 32'h00, 32'hCAFE0001, 4'hF, 1'b0, 0, rd, code);
    access(0, 1'b0, 32'h00, 32'h0, 4'hF, 1'b0, 0, rd, code);
    checks++;
    if (rd !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL unlocked_write got=%h exp=cafe0001", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int          code;
    for (int d = 0; d < NDUT; d += 2) begin
      access(d, 1'b1, word_adr(d, 9),  32'hA5A50001, 4'hF, 1'b1, 0, rd, code);
      access(d, 1'b0, word_adr(d, 9),  32'h0,        4'hF, 1'b1, 1, rd, code);
      access(d, 1'b1, word_adr(d, 10), 32'h5A5A0002, 4'b1100, 1'b1, 1, rd, code);
      access(d, 1'b0, word_adr(d, 10), 32'h0,        4'hF, 1'b0, 1, rd, code);
    end
  endtask

  task automatic test_random(input int d, input int n);
    logic [31:0] b, a, data, rd;
    logic [3:0]  sel;
    logic        we;
    bit          hold;
    int          extra;
    int          code;
    b     = base_of(d);
    extra = 0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(7) == 0) a = $urandom;
      else a = {b[31:6], 4'($urandom_range(15)), 2'($urandom_range(3))};
      data = $urandom;
      we   = 1'($urandom_range(1));
      sel  = ($urandom_range(9) == 0) ? 4'h0 : 4'($urandom_range(15));
      hold = (i != n - 1) && ($urandom_range(3) == 0);
      access(d, we, a, data, sel, hold, extra, rd, code);
      extra = hold ? 1 : 0;
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic [31:0] old;
    int          code;
    old = model_mem[1][5];
    m_adr[1] = word_adr(1, 5); m_din[1] = ~old; m_sel[1] = 4'hF; m_we[1] = 1'b1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(negedge clk);   // first wait cycle
    @(negedge clk);   // second wait cycle
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      checks++;
      if (obs_code(1) != 0) begin
        errors++;
        $display("FAIL abort_no_resp cyc=%0d code=%0d exp=0", j, obs_code(1));
      end
    end
    access(1, 1'b0, word_adr(1, 5), 32'h0, 4'hF, 1'b0, 0, rd, code);
    checks++;
    if (rd !== old) begin
      errors++;
      $display("FAIL abort_no_write got=%h exp=%h", rd, old);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int          code;
    access(1, 1'b1, word_adr(1, 15), 32'h0, 4'h1, 1'b0, 0, rd, code);
    access(1, 1'b1, word_adr(1, 6), 32'h600DF00D, 4'hF, 1'b0, 0, rd, code);
    m_adr[1] = word_adr(1, 7); m_din[1] = 32'h77777777; m_sel[1] = 4'hF; m_we[1] = 1'b1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_quiet("reset_mid_outputs");
    end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    rst = 1'b0;
    clear_model();
    repeat (5) begin
      @(negedge clk);
      check_quiet("reset_mid_no_resp");
    end
    access(1, 1'b0, word_adr(1, 6), 32'h0, 4'hF, 1'b0, 0, rd, code);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_cleared got=%h exp=0", rd);
    end
    access(0, 1'b0, 32'h08, 32'h0, 4'hF, 1'b0, 0, rd, code);
    access(1, 1'b1, word_adr(1, 7), 32'h13579BDF, 4'hF, 1'b0, 0, rd, code);
    checks++;
    if (code != 1) begin
      errors++;
      $display("FAIL after_reset_ack got=%0d exp=1", code);
    end
    access(1, 1'b0, word_adr(1, 7), 32'h0, 4'hF, 1'b0, 0, rd, code);
    checks++;
    if (rd !== 32'h13579BDF) begin
      errors++;
      $display("FAIL after_reset_read got=%h exp=13579bdf", rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_error();
    test_lock();
    test_back_to_back();
    test_random(0, 60);
    test_random(1, 40);
    test_random(2, 60);
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
